// File: rtl/adder_shared_seq.sv
`default_nettype none
// ============================================================================
// Module   : adder_1bit / adder_shared_seq
// Brief    : Full-adder cell, and a chunk-serial WIDTH-bit adder shared by
//            two requesters through a round-robin arbiter.
// Revision : 1.0
// ============================================================================

module adder_1bit #(
    parameter int IMPL_TYPE = 0
) (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);
    logic w_p;

    assign w_p = i_a ^ i_b;
    assign o_s = w_p ^ i_cin;

    // All variants are functionally identical; they only differ in structure.
    generate
        if (IMPL_TYPE == 1) begin : g_mux_carry
            assign o_cout = w_p ? i_cin : i_a;
        end else if (IMPL_TYPE == 2) begin : g_majority
            assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);
        end else begin : g_gen_prop
            assign o_cout = (i_a & i_b) | (w_p & i_cin);
        end
    endgenerate
endmodule

module adder_shared_seq #(
    parameter int WIDTH     = 32,
    parameter int CHUNK     = 8,
    parameter int IMPL_TYPE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_A,
    input  logic [WIDTH-1:0] req0_B,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_A,
    input  logic [WIDTH-1:0] req1_B,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_Sum,
    output logic             rsp_Cout,
    output logic             rsp_id
);
    localparam int C_NCH  = WIDTH / CHUNK;
    localparam int C_IDXW = (C_NCH > 1) ? $clog2(C_NCH) : 1;
    localparam logic [C_IDXW-1:0] C_IDX_LAST = C_IDXW'(C_NCH - 1);
    localparam logic [C_IDXW-1:0] C_IDX_ONE  = C_IDXW'(1);

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_CALC = 2'd1;
    localparam logic [1:0] C_ST_DONE = 2'd2;

    generate
        if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_cfg_check
            $error("adder_shared_seq: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    logic [1:0]        state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic              valid_q, valid_d;
    logic              id_q, id_d;
    logic              last_grant_q, last_grant_d;
    logic [C_IDXW-1:0] idx_q, idx_d;

    logic              w_grant_any;
    logic              w_grant;
    logic [31:0]       w_base;
    logic [CHUNK-1:0]  w_slice_a;
    logic [CHUNK-1:0]  w_slice_b;
    logic [CHUNK-1:0]  w_slice_s;
    logic [CHUNK:0]    w_carry;

    // Round robin only matters on contention; a lone requester always wins.
    assign w_grant_any = req0_valid | req1_valid;
    assign w_grant     = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;

    assign req0_ready = rst_n && (state_q == C_ST_IDLE) && w_grant_any && !w_grant;
    assign req1_ready = rst_n && (state_q == C_ST_IDLE) && w_grant_any &&  w_grant;

    assign w_base    = 32'(idx_q) * 32'(CHUNK);
    assign w_slice_a = a_q[w_base +: CHUNK];
    assign w_slice_b = b_q[w_base +: CHUNK];
    assign w_carry[0] = carry_q;

    generate
        for (genvar gi = 0; gi < CHUNK; gi++) begin : g_cell
            adder_1bit #(
                .IMPL_TYPE (IMPL_TYPE)
            ) u_cell (
                .i_a    (w_slice_a[gi]),
                .i_b    (w_slice_b[gi]),
                .i_cin  (w_carry[gi]),
                .o_s    (w_slice_s[gi]),
                .o_cout (w_carry[gi+1])
            );
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        sum_d        = sum_q;
        carry_d      = carry_q;
        cout_d       = cout_q;
        valid_d      = valid_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        idx_d        = idx_q;

        case (state_q)
            C_ST_IDLE: begin
                if (w_grant_any) begin
                    a_d          = w_grant ? req1_A : req0_A;
                    b_d          = w_grant ? req1_B : req0_B;
                    id_d         = w_grant;
                    last_grant_d = w_grant;
                    carry_d      = 1'b0;
                    idx_d        = '0;
                    state_d      = C_ST_CALC;
                end
            end
            C_ST_CALC: begin
                sum_d[w_base +: CHUNK] = w_slice_s;
                carry_d = w_carry[CHUNK];
                idx_d   = idx_q + C_IDX_ONE;
                if (idx_q == C_IDX_LAST) begin
                    cout_d  = w_carry[CHUNK];
                    valid_d = 1'b1;
                    state_d = C_ST_DONE;
                end
            end
            C_ST_DONE: begin
                if (rsp_ready) begin
                    valid_d = 1'b0;
                    state_d = C_ST_IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = C_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= C_ST_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            sum_q        <= '0;
            carry_q      <= 1'b0;
            cout_q       <= 1'b0;
            valid_q      <= 1'b0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            idx_q        <= '0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sum_q        <= sum_d;
            carry_q      <= carry_d;
            cout_q       <= cout_d;
            valid_q      <= valid_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            idx_q        <= idx_d;
        end
    end

    assign rsp_valid = valid_q;
    assign rsp_Sum   = sum_q;
    assign rsp_Cout  = cout_q;
    assign rsp_id    = id_q;
endmodule

`default_nettype wire

// File: tb/tb_adder_shared_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_shared_seq
// Brief    : Directed self-checking bench for adder_shared_seq (8- and 32-bit
//            chunk instances).
// Revision : 1.0
// ============================================================================

module tb_adder_shared_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_A, req0_B, req1_A, req1_B;
    logic        rsp_valid, rsp_ready, rsp_Cout, rsp_id;
    logic [31:0] rsp_Sum;

    logic        s_req0_valid, s_req1_valid, s_req0_ready, s_req1_ready;
    logic [31:0] s_req0_A, s_req0_B, s_req1_A, s_req1_B;
    logic        s_rsp_valid, s_rsp_ready, s_rsp_Cout, s_rsp_id;
    logic [31:0] s_rsp_Sum;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    adder_shared_seq #(.WIDTH(32), .CHUNK(8), .IMPL_TYPE(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_A(req0_A), .req0_B(req0_B),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_A(req1_A), .req1_B(req1_B),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_Sum(rsp_Sum),
        .rsp_Cout(rsp_Cout), .rsp_id(rsp_id)
    );

    adder_shared_seq #(.WIDTH(32), .CHUNK(32), .IMPL_TYPE(1)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(s_req0_valid), .req0_ready(s_req0_ready), .req0_A(s_req0_A), .req0_B(s_req0_B),
        .req1_valid(s_req1_valid), .req1_ready(s_req1_ready), .req1_A(s_req1_A), .req1_B(s_req1_B),
        .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_Sum(s_rsp_Sum),
        .rsp_Cout(s_rsp_Cout), .rsp_id(s_rsp_id)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Issue one request on the 8-bit-chunk instance with rsp_ready high.
    task automatic run_one(input string tag, input logic rid, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] es, input logic ec);
        int n;
        if (!rid) begin
            req0_A = a; req0_B = b; req0_valid = 1'b1;
        end else begin
            req1_A = a; req1_B = b; req1_valid = 1'b1;
        end
        #1;
        chk({tag, "_ready"}, {req1_ready, req0_ready}, rid ? 2'b10 : 2'b01);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_latency"}, n, 4);
        chk({tag, "_sum"}, rsp_Sum, es);
        chk({tag, "_cout"}, rsp_Cout, ec);
        chk({tag, "_id"}, rsp_id, rid);
        @(posedge clk);
        #1;
        chk({tag, "_drop"}, rsp_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, c, last_c, ngr, nrsp;
        logic gr_seq [4];
        logic seen;

        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_A = '0; req0_B = '0; req1_A = '0; req1_B = '0;
        rsp_ready = 1'b1;
        s_req0_valid = 1'b0; s_req1_valid = 1'b0;
        s_req0_A = '0; s_req0_B = '0; s_req1_A = '0; s_req1_B = '0;
        s_rsp_ready = 1'b1;

        // Reset state, with both requesters asserting valid.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_readies", {req1_ready, req0_ready}, 2'b00);
        chk("rst_outs", {rsp_valid, rsp_Cout, rsp_id, rsp_Sum}, 35'h0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Carry crossing chunk 0 -> 1, then full wrap with carry out.
        run_one("t1", 1'b0, 32'h000000FF, 32'h00000001, 32'h00000100, 1'b0);
        run_one("t2", 1'b1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1);

        // Contention: grants alternate 0,1,0,1 after reset, spaced 6 cycles.
        do_reset();
        req0_A = 32'h00001234; req0_B = 32'h00000001;
        req1_A = 32'hF0000000; req1_B = 32'h20000001;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        ngr = 0; nrsp = 0; last_c = 0;
        for (c = 0; c < 60 && nrsp < 4; c++) begin
            if (rsp_valid) begin
                chk("t3_id", rsp_id, gr_seq[nrsp]);
                chk("t3_sum", {rsp_Cout, rsp_Sum},
                    gr_seq[nrsp] ? 33'h1_10000001 : 33'h0_00001235);
                nrsp++;
            end
            if ((req0_ready || req1_ready) && ngr < 4) begin
                chk("t3_grant", req1_ready, ngr[0]);
                if (ngr > 0) chk("t3_gap", c - last_c, 6);
                last_c = c;
                gr_seq[ngr] = req1_ready;
                ngr++;
            end
            @(posedge clk);
            #1;
            if (ngr == 4) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
        end
        chk("t3_ngrants", ngr, 4);
        chk("t3_nrsp", nrsp, 4);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk);
        #1;

        // Back-pressure: result held 10 cycles while req1 waits.
        rsp_ready = 1'b0;
        req0_A = 32'h0F0F0F0F; req0_B = 32'h01010101; req0_valid = 1'b1;
        #1;
        chk("t4_ready", req0_ready, 1'b1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_A = 32'h00000005; req1_B = 32'h00000003; req1_valid = 1'b1;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t4_latency", n, 4);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("t4_hold", {rsp_valid, rsp_Cout, rsp_id, rsp_Sum}, {3'b100, 32'h10101010});
            chk("t4_rdy", {req1_ready, req0_ready}, 2'b00);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("t4_hs_valid", rsp_valid, 1'b0);
        chk("t4_hs_ready", {req1_ready, req0_ready}, 2'b10);
        run_one("t4b", 1'b1, 32'h00000005, 32'h00000003, 32'h00000008, 1'b0);

        // Asynchronous reset after two CALC edges discards the operation.
        req0_A = 32'hAAAAAAAA; req0_B = 32'h55555555; req0_valid = 1'b1;
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("t5_async_valid", rsp_valid, 1'b0);
        chk("t5_async_rdy", {req1_ready, req0_ready}, 2'b00);
        @(posedge clk);
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen = 1'b1;
        end
        chk("t5_no_rsp", seen, 1'b0);
        run_one("t5b", 1'b0, 32'h12345678, 32'h11111111, 32'h23456789, 1'b0);

        // Single-chunk instance: one-edge latency, carry out of the MSB.
        s_req0_A = 32'h80000000; s_req0_B = 32'h80000000; s_req0_valid = 1'b1;
        #1;
        chk("t6_ready", s_req0_ready, 1'b1);
        @(posedge clk);
        #1;
        s_req0_valid = 1'b0;
        n = 0;
        while (!s_rsp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t6_latency", n, 1);
        chk("t6_sum", s_rsp_Sum, 32'h00000000);
        chk("t6_cout", s_rsp_Cout, 1'b1);
        chk("t6_id", s_rsp_id, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/adder_shared_seq.md
Name: adder_shared_seq

Overview:
- Shares one CHUNK-bit ripple adder slice between two requesters.
- Each request is a WIDTH-bit add, executed least-significant chunk first over WIDTH/CHUNK cycles, with the carry held in a register between chunks.
- Sits in front of the FP mantissa/exponent paths wherever a full-width combinational ripple adder is too large or too slow.
- The slice is built from adder_1bit cells chained inside the block, with the slice carry-in taken from the carry register.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CHUNK, 8, bits added per cycle. WIDTH % CHUNK != 0 is an elaboration error.
- IMPL_TYPE, 0, passed unchanged to every adder_1bit cell.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has operands.
- req0_ready  output  1  requester 0 operands accepted this cycle.
- req0_A  input  WIDTH  requester 0 operand A.
- req0_B  input  WIDTH  requester 0 operand B.
- req1_valid  input  1  requester 1 has operands.
- req1_ready  output  1  requester 1 operands accepted this cycle.
- req1_A  input  WIDTH  requester 1 operand A.
- req1_B  input  WIDTH  requester 1 operand B.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer takes result.
- rsp_Sum  output  WIDTH  (A+B) mod 2^WIDTH.
- rsp_Cout  output  1  carry out of bit WIDTH-1.
- rsp_id  output  1  requester that issued the result.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - state IDLE; rsp_valid 0; rsp_Sum 0; rsp_Cout 0; rsp_id 0.
  - carry register 0; chunk index 0; last_grant 1.
  - req0_ready and req1_ready are 0 while rst_n is low.
- States:
  - IDLE: wait for a request.
  - CALC: one chunk per cycle.
  - DONE: hold the result.
- Arbitration (IDLE only, combinational):
  - Exactly one valid: grant it.
  - Both valid: grant the requester != last_grant. req0 therefore wins first after reset.
  - reqX_ready = (state==IDLE) && grant==X. At most one ready is high per cycle; both are 0 outside IDLE.
- Accept edge (IDLE, granted valid, ready high):
  - Latch A, B and id.
  - carry <= 0; idx <= 0; last_grant <= id; go to CALC.
- CALC, each edge:
  - Slice computes A[idx*CHUNK +: CHUNK] + B[same] + carry.
  - Write the slice result into the result register at the same bit range; carry <= slice carry out; idx <= idx+1.
  - At idx == NCH-1 (NCH = WIDTH/CHUNK): rsp_Cout <= slice carry out, rsp_valid <= 1, go to DONE.
- Latency: rsp_valid goes high on the NCH-th edge after the accept edge. WIDTH=32, CHUNK=8 gives 4 edges. CHUNK=WIDTH gives 1 edge.
- DONE:
  - rsp_Sum, rsp_Cout and rsp_id are stable while rsp_valid && !rsp_ready.
  - On the handshake edge: rsp_valid <= 0 and go to IDLE.
  - There is no accept in the same cycle as the handshake, so the minimum issue period is NCH+2 cycles.
- rsp_Sum bits not yet written during CALC are don't-care. The bench checks rsp_Sum only when rsp_valid=1.
- Requester inputs are sampled only on the accept edge. Changes after acceptance have no effect.
- Requester 1 valid during CALC/DONE: it is not acknowledged. It wins the next IDLE if req0 was served last.
- Reset mid-operation (any state): outputs go to reset values immediately. The in-flight operation is discarded and no response is issued. After release, normal operation resumes from IDLE.

Test Plan:
- WIDTH=32, CHUNK=8, req0 A=0x000000FF, B=0x00000001, rsp_ready=1 -> rsp_Sum=0x00000100, rsp_Cout=0, rsp_id=0, rsp_valid exactly 4 edges after the accept edge (carry crosses a chunk).
- req1 A=0xFFFFFFFF, B=0x00000001 -> rsp_Sum=0x00000000, rsp_Cout=1, rsp_id=1.
- Both valid continuously, distinct operands, rsp_ready=1 -> grants 0,1,0,1; req0 first after reset; accepts spaced 6 cycles; each rsp_id matches its operands.
- Result pending, rsp_ready held low 10 cycles -> rsp_valid, rsp_Sum, rsp_Cout and rsp_id unchanged; both readies 0. Raise rsp_ready -> handshake, then IDLE and ready the next cycle.
- rst_n low asynchronously after 2 CALC edges -> rsp_valid=0 and readies 0 without a clock edge; no response after release. Next req0 A=0x12345678, B=0x11111111 -> rsp_Sum=0x23456789, rsp_Cout=0.
- CHUNK=32 instance, A=0x80000000, B=0x80000000 -> rsp_Sum=0, rsp_Cout=1, rsp_valid 1 edge after accept.
